// File: rtl/pcie_ep_sched_if.sv
// Requester-side bundle of the endpoint TRN scheduler: level requests, driven flags,
// per-requester weights, and the scheduler's grant/ownership status.
interface pcie_ep_sched_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WEIGHT_W = 4
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0]          drvn;
  logic [NUM_REQ*WEIGHT_W-1:0] weight;
  logic [NUM_REQ-1:0]          grant;
  logic [2:0]                  owner;
  logic                        owner_vld;
  logic                        forfeit;
  logic                        wdog_err;

  modport master (
    input  req, drvn, weight,
    output grant, owner, owner_vld, forfeit, wdog_err
  );

  modport slave (
    output req, drvn, weight,
    input  grant, owner, owner_vld, forfeit, wdog_err
  );
endinterface

// File: rtl/pcie_ep_sched.sv
// pcie_ep_sched: weighted round-robin turn scheduler with one priority requester.
// Define PCIE_EP_SCHED_WDOG_EN to build the OWNED-cycle watchdog behind wdog_err.
module pcie_ep_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WEIGHT_W    = 4,
  parameter int unsigned HIPRI_IDX   = 3,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned MAX_OWN     = 4096
) (
  input  logic clk,
  input  logic rst,
  pcie_ep_sched_if.master bus
);
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || HIPRI_IDX >= NUM_REQ || ACK_TIMEOUT < 1 ||
      MAX_OWN < 1 || MAX_OWN > 8191) begin : g_bad_cfg
    $error("pcie_ep_sched: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, GRANT, WAIT_ACK, OWNED, GAP} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [2:0]          owner_q, owner_d;
  logic [2:0]          burst_q, burst_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic                hipri_last_q, hipri_last_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;

  logic [7:0]          req8, drvn8;
  logic                own_drvn;
  logic                win_ovr, win_burst;
  logic [2:0]          scan_base, win;
  logic [WEIGHT_W-1:0] load_w;
  logic [NUM_REQ-1:0]  win_oh;
  logic                found;

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    if (32'(v) >= NUM_REQ - 1) return '0;
    return v + 3'd1;
  endfunction

  always_comb begin
    req8  = '0;
    drvn8 = '0;
    req8[NUM_REQ-1:0]  = bus.req;
    drvn8[NUM_REQ-1:0] = bus.drvn;
  end

  assign own_drvn = drvn8[owner_q];

  // Burst continuation tracks the last non-override winner, so an interrupt turn
  // slots into the middle of a burst without hijacking its remaining credit.
  always_comb begin
    win_ovr   = bus.req[HIPRI_IDX] && !hipri_last_q;
    win_burst = !win_ovr && (credit_q != '0) && req8[burst_q];
    scan_base = rr_ptr_q;
    if (credit_q != '0 && !req8[burst_q]) scan_base = wrap_inc(burst_q);
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = 32'(scan_base) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req8[3'(idx)]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    if (win_ovr)        win = 3'(HIPRI_IDX);
    else if (win_burst) win = burst_q;
    load_w = '0;
    win_oh = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (3'(k) == win) begin
        load_w    = bus.weight[k*WEIGHT_W +: WEIGHT_W];
        win_oh[k] = 1'b1;
      end
    end
    if (load_w == '0) load_w = WEIGHT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      burst_q      <= '0;
      rr_ptr_q     <= '0;
      credit_q     <= '0;
      hipri_last_q <= 1'b0;
      tmr_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      burst_q      <= burst_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_q     <= credit_d;
      hipri_last_q <= hipri_last_d;
      tmr_q        <= tmr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = '0;
    owner_d      = owner_q;
    burst_d      = burst_q;
    rr_ptr_d     = rr_ptr_q;
    credit_d     = credit_q;
    hipri_last_d = hipri_last_q;
    tmr_d        = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.drvn == '0 && bus.req != '0) begin
          state_d      = GRANT;
          grant_d      = win_oh;
          owner_d      = win;
          hipri_last_d = win_ovr;
          if (!win_ovr) begin
            burst_d  = win;
            credit_d = (win_burst ? credit_q : load_w) - WEIGHT_W'(1);
            if (credit_d == '0) rr_ptr_d = wrap_inc(win);
          end
        end
      end
      GRANT: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (own_drvn) begin
          state_d = OWNED;
        end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          state_d  = GAP;
          credit_d = '0;
          rr_ptr_d = wrap_inc(owner_q);
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      OWNED: if (!own_drvn) state_d = GAP;
      GAP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef PCIE_EP_SCHED_WDOG_EN
  logic [12:0] own_cnt_q, own_cnt_d;
  logic        wdog_q, wdog_d;

  always_comb begin
    own_cnt_d = '0;
    wdog_d    = wdog_q;
    if (state_q == OWNED) begin
      own_cnt_d = (own_cnt_q == '1) ? own_cnt_q : own_cnt_q + 13'd1;
      if (own_cnt_q == 13'(MAX_OWN - 1)) wdog_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_cnt_q <= '0;
      wdog_q    <= 1'b0;
    end else begin
      own_cnt_q <= own_cnt_d;
      wdog_q    <= wdog_d;
    end
  end
`else
  logic wdog_q;
  assign wdog_q = 1'b0;
`endif

  always_comb begin
    bus.grant     = grant_q;
    bus.owner     = owner_q;
    bus.owner_vld = (state_q == GRANT) || (state_q == WAIT_ACK) || (state_q == OWNED);
    bus.forfeit   = (state_q == WAIT_ACK) && !own_drvn && (tmr_q == TMR_W'(ACK_TIMEOUT - 1));
    bus.wdog_err  = wdog_q;
  end
endmodule

// File: tb/tb_pcie_ep_sched.sv
// Directed bench for pcie_ep_sched: rotation, weighted bursts, priority override,
// forfeit timing, reset mid-turn and the optional watchdog.
module tb_pcie_ep_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef PCIE_EP_SCHED_WDOG_EN
  localparam int WDOG = 1;
`else
  localparam int WDOG = 0;
`endif

  pcie_ep_sched_if #(.NUM_REQ(4), .WEIGHT_W(4)) bus ();

  pcie_ep_sched #(
    .NUM_REQ(4), .WEIGHT_W(4), .HIPRI_IDX(3), .ACK_TIMEOUT(16), .MAX_OWN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) r = (r == -1) ? i : -2;
    end
    return r;
  endfunction

  // Returns the granted index (-1 on timeout, -2 if not one-hot).
  task automatic wait_grant(output int idx);
    idx = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.grant != '0) begin
        idx = oh_idx(bus.grant);
        break;
      end
    end
  endtask

  task automatic turn(input int exp, input int hold, input string tag);
    int g;
    wait_grant(g);
    chk({tag, " grant"}, g, exp);
    if (g >= 0) begin
      bus.drvn[g] = 1'b1;
      @(negedge clk);
      chk({tag, " owner"}, int'(bus.owner), exp);
      chk({tag, " owner_vld"}, int'(bus.owner_vld), 1);
      repeat (hold - 1) @(negedge clk);
      bus.drvn[g] = 1'b0;
    end
  endtask

  initial begin
    int g;
    int seen;
    bus.req    = '0;
    bus.drvn   = '0;
    bus.weight = 16'h1111;

    repeat (3) @(negedge clk);
    chk("rst grant", int'(bus.grant), 0);
    chk("rst owner", int'(bus.owner), 0);
    chk("rst owner_vld", int'(bus.owner_vld), 0);
    chk("rst forfeit", int'(bus.forfeit), 0);
    chk("rst wdog_err", int'(bus.wdog_err), 0);
    rst = 1'b0;

    // Round robin; a non-owner drvn keeps IDLE from granting.
    bus.req = 4'b0111;
    turn(0, 3, "rr0");
    bus.drvn[2] = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.grant != '0) seen = 1;
    end
    chk("rr blocked by drvn", seen, 0);
    bus.drvn[2] = 1'b0;
    turn(1, 3, "rr1");
    turn(2, 3, "rr2");
    turn(0, 3, "rr3");
    turn(1, 3, "rr4");
    turn(2, 3, "rr5");

    // Weighted burst: w0=3, w1=1.
    bus.weight = 16'h1113;
    bus.req    = 4'b0011;
    turn(0, 2, "wb0");
    turn(0, 2, "wb1");
    turn(0, 2, "wb2");
    turn(1, 2, "wb3");
    turn(0, 2, "wb4");
    turn(0, 2, "wb5");
    turn(0, 2, "wb6");
    turn(1, 2, "wb7");

    // Priority override: 0, then 3, 1, 3.
    bus.weight = 16'h1111;
    bus.req    = 4'b0001;
    wait_grant(g);
    chk("pri0 grant", g, 0);
    bus.req     = 4'b1011;
    bus.drvn[0] = 1'b1;
    repeat (2) @(negedge clk);
    bus.drvn[0] = 1'b0;
    turn(3, 2, "pri1");
    turn(1, 2, "pri2");
    turn(3, 2, "pri3");

    // Forfeit: requester 2 (weight 2) never drives.
    bus.weight = 16'h1211;
    bus.req    = 4'b0100;
    wait_grant(g);
    chk("ff grant", g, 2);
    bus.req = 4'b0111;
    seen = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.forfeit) begin
        seen = c;
        break;
      end
    end
    chk("ff delay", seen, 16);
    @(negedge clk);
    chk("ff one-shot", int'(bus.forfeit), 0);
    turn(0, 2, "ff next");

    // Reset mid-turn.
    bus.req = 4'b0110;
    wait_grant(g);
    chk("rmt grant", g, 1);
    bus.drvn[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rmt owned vld", int'(bus.owner_vld), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rmt grant0", int'(bus.grant), 0);
    chk("rmt owner0", int'(bus.owner), 0);
    chk("rmt vld0", int'(bus.owner_vld), 0);
    chk("rmt forfeit0", int'(bus.forfeit), 0);
    bus.drvn[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_grant(g);
    chk("rmt first grant", g, 1);

    // Watchdog: drvn held 20 cycles.
    if (g >= 0) bus.drvn[g] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 9)  chk("wdog before limit", int'(bus.wdog_err), 0);
      if (c == 10) chk("wdog at limit", int'(bus.wdog_err), WDOG);
    end
    bus.drvn = '0;
    bus.req  = '0;
    repeat (4) @(negedge clk);
    chk("wdog sticky", int'(bus.wdog_err), WDOG);
    chk("idle owner_vld", int'(bus.owner_vld), 0);
    chk("idle owner", int'(bus.owner), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
